ssd_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. It holds eight BCD digits and walks one active-low anode at a time, with a dead-time blanking gap before each digit. It decodes each digit to the team's active-low segment patterns. New display words arrive through a valid/ready load port and are double-buffered, so they are applied only at a frame boundary and the display never shows a torn mix of old and new digits.

---
 rtl/ssd_scan_ctrl.sv | 102 ++++++++++
 tb/tb_ssd_scan_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: eight-digit multiplexed seven-segment scanner with dead-time blanking
// and a double-buffered load port that updates only at frame boundaries.
module ssd_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_value,
    input  logic [7:0]  load_blank,
    output logic [0:6]  seg,
    output logic [7:0]  digit,
    output logic        frame_done
);
    localparam int CW = $clog2(REFRESH_DIV);

    typedef enum logic {BLANK, SHOW} state_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   disp_val_q, disp_val_d, pend_val_q, pend_val_d;
    logic [7:0]    disp_blank_q, disp_blank_d, pend_blank_q, pend_blank_d;
    logic          pend_q, pend_d;
    logic [0:6]    seg_q, seg_d;
    logic [7:0]    digit_q, digit_d;
    logic          fd_q, fd_d;
    state_t        state_q, state_d;
    logic          accept, last, boundary, apply;
    logic [3:0]    nib;

    function automatic logic [0:6] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0000100;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        accept       = load_valid & ~pend_q;
        last         = cnt_q == CW'(REFRESH_DIV - 1);
        boundary     = en & last & (idx_q == 3'd7);
        apply        = pend_q & (~en | boundary);
        cnt_d        = (~en | last) ? '0 : cnt_q + 1'b1;
        idx_d        = ~en ? 3'd0 : (last ? idx_q + 3'd1 : idx_q);
        disp_val_d   = apply ? pend_val_q : disp_val_q;
        disp_blank_d = apply ? pend_blank_q : disp_blank_q;
        pend_d       = accept | (pend_q & ~apply);
        pend_val_d   = accept ? load_value : pend_val_q;
        pend_blank_d = accept ? load_blank : pend_blank_q;
        // Outputs are computed from next state so they register with zero added latency.
        state_d      = (en && cnt_d >= CW'(BLANK_CYC)) ? SHOW : BLANK;
        nib          = disp_val_d[{idx_d, 2'b00} +: 4];
        digit_d      = (state_d == SHOW) ? ~(8'd1 << idx_d) : 8'hFF;
        seg_d        = (state_d == SHOW && !disp_blank_d[idx_d]) ? decode(nib) : 7'h7F;
        fd_d         = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_val_q   <= '0;
            disp_blank_q <= 8'hFF;
            pend_val_q   <= '0;
            pend_blank_q <= '0;
            pend_q       <= 1'b0;
            state_q      <= BLANK;
            seg_q        <= 7'h7F;
            digit_q      <= 8'hFF;
            fd_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_val_q   <= disp_val_d;
            disp_blank_q <= disp_blank_d;
            pend_val_q   <= pend_val_d;
            pend_blank_q <= pend_blank_d;
            pend_q       <= pend_d;
            state_q      <= state_d;
            seg_q        <= (state_d == SHOW) ? seg_d : 7'h7F;
            digit_q      <= digit_d;
            fd_q         <= fd_d;
        end
    end

    assign load_ready = ~pend_q;
    assign seg        = (state_q == SHOW) ? seg_q : 7'h7F;
    assign digit      = digit_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: scoreboard bench; a cycle-position reference model predicts every
// output cycle, and a monitor compares the DUT against the queued predictions.
module tb_ssd_scan_ctrl;
    logic        clk = 0, rst_n = 0, en = 0, load_valid = 0;
    logic [31:0] load_value = 0;
    logic [7:0]  load_blank = 0;
    logic        load_ready, frame_done;
    logic [0:6]  seg;
    logic [7:0]  digit;

    typedef struct packed {
        logic [6:0] seg;
        logic [7:0] digit;
        logic       rdy;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;

    int         pos = 0;
    logic [3:0] m_val[8], p_val[8];
    logic [7:0] m_blank = 8'hFF, p_blank = 0;
    bit         m_pend = 0;
    logic [6:0] tbl[10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    ssd_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load_valid(load_valid), .load_ready(load_ready),
        .load_value(load_value), .load_blank(load_blank), .seg(seg), .digit(digit),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Predict the outputs after the coming rising edge from the current inputs.
    task automatic model_step();
        exp_t e;
        bit acc, bnd, lit;
        int d;
        bnd = 0;
        if (!rst_n) begin
            pos = 0;
            m_pend = 0;
            m_blank = 8'hFF;
            foreach (m_val[i]) m_val[i] = 0;
        end else begin
            acc = load_valid && !m_pend;
            if (en) begin
                bnd = (pos % 64) == 63;
                pos++;
                if (bnd && m_pend) begin m_val = p_val; m_blank = p_blank; m_pend = 0; end
            end else begin
                pos = 0;
                if (m_pend) begin m_val = p_val; m_blank = p_blank; m_pend = 0; end
            end
            if (acc) begin
                foreach (p_val[i]) p_val[i] = load_value[4*i +: 4];
                p_blank = load_blank;
                m_pend = 1;
            end
        end
        d = (pos / 8) % 8;
        lit = rst_n && en && (pos % 8) >= 2;
        e.fd = bnd;
        e.rdy = !m_pend;
        e.digit = lit ? ~(8'd1 << d) : 8'hFF;
        e.seg = (lit && !m_blank[d] && m_val[d] < 10) ? tbl[m_val[d]] : 7'h7F;
        q.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic load(input logic [31:0] v, input logic [7:0] b);
        load_valid = 1; load_value = v; load_blank = b;
        tick();
        load_valid = 0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("seg", 32'(seg), 32'(e.seg));
            check("digit", 32'(digit), 32'(e.digit));
            check("load_ready", 32'(load_ready), 32'(e.rdy));
            check("frame_done", 32'(frame_done), 32'(e.fd));
        end
    end

    initial begin
        foreach (m_val[i]) begin m_val[i] = 0; p_val[i] = 0; end
        @(negedge clk);
        run(3);
        rst_n = 1; en = 1;
        run(70);
        en = 0;
        load(32'h76543210, 8'h00);
        en = 1;
        run(140);
        while ((pos / 8) % 8 != 3) tick();
        load(32'h99999999, 8'h00);
        run(5);
        load(32'h11111111, 8'h00);
        run(140);
        load(32'h0000A005, 8'b0000_0100);
        run(140);
        load(32'h12345678, 8'h00);
        while (pos % 8 != 4) tick();
        en = 0;
        run(3);
        en = 1;
        run(80);
        while ((pos / 8) % 8 != 5) tick();
        rst_n = 0;
        #1;
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_digit", 32'(digit), 32'hFF);
        check("rst_ready", 32'(load_ready), 32'h1);
        check("rst_fd", 32'(frame_done), 32'h0);
        run(2);
        rst_n = 1;
        run(80);
        repeat (2000) begin
            logic [31:0] v;
            for (int i = 0; i < 8; i++) v[4*i +: 4] = 4'($urandom_range(0, 11));
            en = $urandom_range(0, 19) != 0;
            load_valid = $urandom_range(0, 9) == 0;
            load_value = v;
            load_blank = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            rst_n = $urandom_range(0, 499) != 0;
            tick();
        end
        rst_n = 1; en = 1; load_valid = 0;
        run(4);
        @(posedge clk);
        #2;
        check("drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
